// File: rtl/seq_lane_serializer.sv
// Serializes a variable-length word (0..W valid bits) into 2-bit chunks with per-lane enables.
// Define SEQ_LANE_SERIALIZER_MSB_FIRST_EN to emit from in_data[nbits-1] downward (default: LSB first).
module seq_lane_serializer #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic [$clog2(W):0]   in_nbits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_data,
  output logic [1:0]           out_en,
  output logic                 out_last
);
  localparam int NB = $clog2(W) + 1;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t          r_state, w_state_n;
  logic [W-1:0]    r_shreg, w_shreg_n, w_load;
  logic [NB-1:0]   r_rem, w_rem_n, w_nb;
  logic [1:0]      r_out_data, r_out_en, w_data_n, w_en_n;
  logic            r_out_last, w_last_n;
  logic            w_acc, w_hs;

  assign w_nb = (in_nbits > NB'(W)) ? NB'(W) : in_nbits;

`ifdef SEQ_LANE_SERIALIZER_MSB_FIRST_EN
  // Left-align so the next bit to emit always sits at the top; stale upper bits fall off.
  assign w_load = in_data << (W - int'(w_nb));
`else
  assign w_load = in_data & ({W{1'b1}} >> (W - int'(w_nb)));
`endif

  assign out_valid = (r_state == S_SHIFT);
  assign in_ready  = (r_state == S_IDLE) || (r_out_last && out_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_hs      = out_valid && out_ready;
  assign out_data  = r_out_data;
  assign out_en    = r_out_en;
  assign out_last  = r_out_last;

  always_comb begin
    w_state_n = r_state;
    w_shreg_n = r_shreg;
    w_rem_n   = r_rem;
    if (w_hs) begin
      if (r_out_last) begin
        w_state_n = S_IDLE;
        w_shreg_n = '0;
        w_rem_n   = '0;
      end else begin
`ifdef SEQ_LANE_SERIALIZER_MSB_FIRST_EN
        w_shreg_n = r_shreg << 2;
`else
        w_shreg_n = r_shreg >> 2;
`endif
        w_rem_n   = r_rem - NB'(2);
      end
    end
    // In SHIFT an accept only happens alongside the last-chunk handshake, so loading wins.
    if (w_acc && (w_nb != '0)) begin
      w_state_n = S_SHIFT;
      w_shreg_n = w_load;
      w_rem_n   = w_nb;
    end
  end

  always_comb begin
    w_data_n = 2'b00;
    w_en_n   = 2'b00;
    if (w_rem_n >= NB'(2)) begin
      w_en_n = 2'b11;
`ifdef SEQ_LANE_SERIALIZER_MSB_FIRST_EN
      w_data_n = w_shreg_n[W-1:W-2];
`else
      w_data_n = w_shreg_n[1:0];
`endif
    end else if (w_rem_n == NB'(1)) begin
      w_en_n = 2'b01;
`ifdef SEQ_LANE_SERIALIZER_MSB_FIRST_EN
      w_data_n = {1'b0, w_shreg_n[W-1]};
`else
      w_data_n = {1'b0, w_shreg_n[0]};
`endif
    end
    w_last_n = (w_state_n == S_SHIFT) && (w_rem_n <= NB'(2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_rem      <= '0;
      r_out_data <= 2'b00;
      r_out_en   <= 2'b00;
      r_out_last <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_shreg    <= w_shreg_n;
      r_rem      <= w_rem_n;
      r_out_data <= w_data_n;
      r_out_en   <= w_en_n;
      r_out_last <= w_last_n;
    end
  end
endmodule

// File: tb/tb_seq_lane_serializer.sv
// Directed bench for seq_lane_serializer: a chunk-queue model checked every cycle,
// plus literal expectations for the reference words.
module tb_seq_lane_serializer;
  localparam int W  = 8;
  localparam int NB = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic [NB-1:0] in_nbits = '0;
  logic          in_ready, out_valid, out_last;
  logic [1:0]    out_data, out_en;

  seq_lane_serializer #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_nbits(in_nbits),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_en(out_en),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] d; logic [1:0] e; logic l; } chunk_t;

  chunk_t q[$];
  chunk_t log_q[$];
  bit     mon_en = 1'b0;
  int     n_vec = 0;
  int     n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Chunk list for one word, straight from the bit-ordering rules.
  function automatic void model_push(input logic [W-1:0] d, input int nb);
    int n;
    chunk_t c;
    n = (nb > W) ? W : nb;
`ifdef SEQ_LANE_SERIALIZER_MSB_FIRST_EN
    for (int k = n - 1; k >= 0; k -= 2) begin
      if (k >= 1) begin c.d = {d[k], d[k-1]}; c.e = 2'b11; end
      else        begin c.d = {1'b0, d[0]};   c.e = 2'b01; end
      c.l = (k <= 1);
      q.push_back(c);
    end
`else
    for (int i = 0; i < n; i += 2) begin
      if (i + 1 < n) begin c.d = {d[i+1], d[i]}; c.e = 2'b11; end
      else           begin c.d = {1'b0, d[i]};   c.e = 2'b01; end
      c.l = (i + 2 >= n);
      q.push_back(c);
    end
`endif
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_rdy;
      exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("out_valid", 8'(out_valid), 8'(q.size() != 0));
      chk("in_ready", 8'(in_ready), 8'(exp_rdy));
      if (q.size() != 0) begin
        chk("out_data", 8'(out_data), 8'(q[0].d));
        chk("out_en", 8'(out_en), 8'(q[0].e));
        chk("out_last", 8'(out_last), 8'(q[0].l));
      end
      if (rst) q.delete();
      else begin
        if (q.size() != 0 && out_ready) begin
          log_q.push_back(q[0]);
          void'(q.pop_front());
        end
        if (in_valid && exp_rdy) model_push(in_data, int'(in_nbits));
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [NB-1:0] n);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_nbits = n;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout: word %0h never accepted", d);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = !out_valid && (q.size() == 0);
    end
    @(posedge clk); #1;
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: output still busy");
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [1:0] d,
                         input logic [1:0] e, input logic l);
    chk({nm, "_d"}, 8'(log_q[idx].d), 8'(d));
    chk({nm, "_e"}, 8'(log_q[idx].e), 8'(e));
    chk({nm, "_l"}, 8'(log_q[idx].l), 8'(l));
  endtask

  initial begin
    logic [1:0] b4[4];
    logic [1:0] h15[3];
    logic [7:0] pat;
`ifdef SEQ_LANE_SERIALIZER_MSB_FIRST_EN
    b4  = '{2'b10, 2'b11, 2'b01, 2'b00};
    h15 = '{2'b10, 2'b10, 2'b01};
`else
    b4  = '{2'b00, 2'b01, 2'b11, 2'b10};
    h15 = '{2'b01, 2'b01, 2'b01};
`endif
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_in_ready", 8'(in_ready), 8'd1);
    chk("rst_out_data", 8'(out_data), 8'd0);
    chk("rst_out_en", 8'(out_en), 8'd0);
    chk("rst_out_last", 8'(out_last), 8'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Reference word, full width
    log_q.delete();
    send(8'hB4, 4'd8); drain();
    chk("b4_count", 8'(log_q.size()), 8'd4);
    for (int i = 0; i < 4; i++) chk_log("b4", i, b4[i], 2'b11, i == 3);

    // Odd length: single-bit final chunk
    log_q.delete();
    send(8'h15, 4'd5); drain();
    chk("h15_count", 8'(log_q.size()), 8'd3);
    for (int i = 0; i < 3; i++) chk_log("h15", i, h15[i], (i == 2) ? 2'b01 : 2'b11, i == 2);

    // Backpressure mid-word
    log_q.delete();
    send(8'hA5, 4'd8);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    chk("bp_count", 8'(log_q.size()), 8'd4);

    // Back-to-back words
    log_q.delete();
    send(8'h3C, 4'd8); send(8'h96, 4'd7); send(8'h5A, 4'd3); drain();
    chk("b2b_count", 8'(log_q.size()), 8'd10);

    // Zero-length word: consumed, nothing emitted
    log_q.delete();
    send(8'hFF, 4'd0);
    repeat (3) @(posedge clk);
    #1 chk("zero_count", 8'(log_q.size()), 8'd0);

    // nbits above W clamps to W
    log_q.delete();
    send(8'hC3, 4'd15); drain();
    chk("clamp_count", 8'(log_q.size()), 8'd4);
    chk_log("clamp_last", 3, 2'b11, 2'b11, 1'b1);

    // Reset after two chunks abandons the word
    log_q.delete();
    send(8'hFF, 4'd8);
    for (int i = 0; i < 20 && log_q.size() < 2; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 8'(out_valid), 8'd0);
    chk("midrst_ready", 8'(in_ready), 8'd1);
    @(posedge clk); #1;
    chk("midrst_count", 8'(log_q.size()), 8'd2);
    send(8'h6E, 4'd6); drain();
    chk("post_rst_count", 8'(log_q.size()), 8'd5);

    // Odd lengths under an irregular ready pattern
    log_q.delete();
    pat = 8'b1011_0110;
    fork
      begin
        send(8'h9D, 4'd7); send(8'h42, 4'd1); send(8'hE7, 4'd2); send(8'h1B, 4'd8);
      end
      begin
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1 out_ready = pat[i % 8]; end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("mix_count", 8'(log_q.size()), 8'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_lane_serializer.md
SEQ_LANE_SERIALIZER -- requirements
Module: seq_lane_serializer

Interface
REQ-001 Parameter W, default 8, input word width in bits; the value SHALL be even and >= 4.
REQ-002 clk  input  1  clock; all state SHALL update on posedge clk only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  in_data/in_nbits valid this cycle.
REQ-005 in_ready  output  1  block accepts the word when in_valid && in_ready.
REQ-006 in_data  input  W  word to serialize.
REQ-007 in_nbits  input  $clog2(W)+1  count of valid bits in in_data, 0..W.
REQ-008 out_valid  output  1  out_data/out_en valid this cycle.
REQ-009 out_ready  input  1  sink consumes the chunk when out_valid && out_ready.
REQ-010 out_data  output  2  current 2-bit chunk.
REQ-011 out_en  output  2  per-bit lane enable of the chunk: 2'b11 full, 2'b01 single bit (bit 0 only).
REQ-012 out_last  output  1  current chunk is the final chunk of the word.

Function
REQ-013 The FSM SHALL have two states: IDLE (in_ready=1, out_valid=0) and SHIFT (out_valid=1).
REQ-014 IDLE, accept with in_nbits>0: SHALL latch in_data and in_nbits and enter SHIFT; the first chunk SHALL be on out_data the next cycle (latency 1).
REQ-015 IDLE, accept with in_nbits==0: SHALL consume the word, stay in IDLE, and emit nothing.
REQ-016 SHIFT: out_data/out_en/out_last SHALL stay stable while out_ready=0 (no chunk loss, no advance).
REQ-017 SHIFT, handshake on a non-last chunk: SHALL advance 2 bits and decrement the remaining count by 2.
REQ-018 out_en SHALL be 2'b11 when remaining >= 2 and 2'b01 when remaining == 1; an unused lane in out_data SHALL be 0.
REQ-019 out_last SHALL be 1 exactly when remaining <= 2.
REQ-020 in_ready SHALL be 1 in IDLE, and in SHIFT when out_last && out_ready (combinational pass-through) so back-to-back words need no bubble.
REQ-021 Last-chunk handshake with a simultaneous accept (nbits>0): SHALL stay in SHIFT with the new word loaded; first chunk appears next cycle.
REQ-022 Last-chunk handshake without an accept: SHALL return to IDLE.
REQ-023 in_nbits > W SHALL be clamped to W.
REQ-024 Chunk count per word SHALL be ceil(in_nbits/2); bits of in_data beyond in_nbits SHALL never appear on out_data.

Reset
REQ-025 With rst=1 at a posedge: state=IDLE, shift register=0, remaining=0, out_valid=0, out_data=0, out_en=0, out_last=0, in_ready=1 from the following cycle.
REQ-026 Reset during SHIFT SHALL abandon the partial word; no further chunk of it SHALL appear.
REQ-027 rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-028 Macro SEQ_LANE_SERIALIZER_MSB_FIRST_EN defined: bits SHALL be emitted from in_data[nbits-1] downward; out_data[1] carries the higher-index bit; a single final bit SHALL be in_data[0] on out_data[0].
REQ-029 Macro SEQ_LANE_SERIALIZER_MSB_FIRST_EN undefined: bits SHALL be emitted from in_data[0] upward; out_data[0] carries the lower-index bit.

Verification
REQ-030 LSB build, W=8, in_data=8'hB4, nbits=8, out_ready=1 -> chunks 2'b00, 2'b01, 2'b11, 2'b10; out_en=11 each; out_last only on 4th; in_ready high with 4th chunk.
REQ-031 LSB build, in_data=8'h15, nbits=5 -> chunks 01, 01, 01 with out_en 11, 11, 01; last chunk out_data=2'b01.
REQ-032 Backpressure: out_ready=0 for 3 cycles mid-word -> out_data/out_en/out_last held constant; no chunk skipped or repeated.
REQ-033 Back-to-back: second word valid during last chunk -> first chunk of the second word on the very next cycle; out_valid never drops.
REQ-034 rst pulsed after 2 chunks of 8'hFF -> out_valid=0 next cycle, in_ready=1, no remaining chunks emitted; a new word then serializes normally.
REQ-035 MSB build, in_data=8'hB4, nbits=8 -> chunks 10, 11, 01, 00; nbits=0 word -> accepted with no out_valid.
